// File: rtl/c_fetch_aligner.sv
// c_fetch_aligner
//   Fetches 32-bit aligned words from instruction memory into a 4-entry
//   halfword buffer and presents exactly one instruction per handshake,
//   16-bit compressed or 32-bit, including 32-bit instructions that straddle
//   a word boundary. The decoder always receives the instruction in [15:0]
//   (compressed) or [31:0] (full), with its PC alongside.
//
// Ports
//   clk, rst_n           core clock, asynchronous active-low reset
//   redirect_i           flush buffer and restart fetch at redirect_pc_i
//   redirect_pc_i        new PC (bit 0 ignored)
//   imem_req_o           fetch request, held until imem_ack_i
//   imem_addr_o          word-aligned fetch address, stable during request
//   imem_ack_i           response valid (may coincide with request cycle)
//   imem_rdata_i         fetched word, halfword 0 in [15:0]
//   inst_valid_o         instruction available
//   inst_ready_i         decoder accepts
//   inst_o               instruction; compressed is {16'h0, hw}
//   inst_pc_o            PC of inst_o
//   inst_is_comp_o       1 = 16-bit instruction
module c_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_is_comp_o
);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_t;

  state_t            state_q;
  logic [3:0][15:0]  hbuf_q;
  logic [3:0][15:0]  hbuf_d;
  logic [2:0]        count_q;
  logic [2:0]        count_d;
  logic [31:0]       head_pc_q;
  logic [31:0]       fetch_ptr_q;
  logic [31:0]       req_addr_q;
  logic              skip_half_q;
  logic              discard_q;

  logic              is_comp;
  logic              fire;
  logic              take;
  logic [2:0]        consumed;
  logic [2:0]        appended;
  logic [2:0]        surv;
  logic [15:0]       app0;
  logic [15:0]       app1;
  logic [2:0]        idx;
  logic [2:0]        src;
  logic [2:0]        slot;

  // Instruction presentation, straight from the buffer registers.
  always_comb begin
    is_comp        = (hbuf_q[0][1:0] != 2'b11);
    inst_valid_o   = !redirect_i &&
                     (((count_q >= 3'd1) && is_comp) || (count_q >= 3'd2));
    inst_o         = is_comp ? {16'h0000, hbuf_q[0]} : {hbuf_q[1], hbuf_q[0]};
    inst_pc_o      = head_pc_q;
    inst_is_comp_o = (count_q != 3'd0) && is_comp;
    imem_req_o     = (state_q == S_REQ);
    imem_addr_o    = req_addr_q;
  end

  // Next buffer contents: drop consumed halfwords from the front, then place
  // the newly fetched halfwords directly behind the surviving entries.
  always_comb begin
    fire     = inst_valid_o && inst_ready_i;
    consumed = fire ? (is_comp ? 3'd1 : 3'd2) : 3'd0;
    take     = (state_q == S_REQ) && imem_ack_i && !discard_q && !redirect_i;
    appended = take ? (skip_half_q ? 3'd1 : 3'd2) : 3'd0;
    app0     = skip_half_q ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
    app1     = imem_rdata_i[31:16];
    surv     = count_q - consumed;
    count_d  = surv + appended;
    hbuf_d   = '0;
    idx      = '0;
    src      = '0;
    slot     = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx  = 3'(i);
      src  = idx + consumed;
      slot = idx - surv;
      if (src < count_q) begin
        hbuf_d[i] = hbuf_q[src[1:0]];
      end else if ((idx >= surv) && (slot < appended)) begin
        hbuf_d[i] = slot[0] ? app1 : app0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hbuf_q      <= '0;
      count_q     <= '0;
      head_pc_q   <= RESET_PC;
      fetch_ptr_q <= {RESET_PC[31:2], 2'b00};
      req_addr_q  <= {RESET_PC[31:2], 2'b00};
      skip_half_q <= RESET_PC[1];
      discard_q   <= 1'b0;
    end else if (redirect_i) begin
      hbuf_q      <= '0;
      count_q     <= '0;
      head_pc_q   <= redirect_pc_i & ~32'h1;
      fetch_ptr_q <= redirect_pc_i & ~32'h3;
      skip_half_q <= redirect_pc_i[1];
      // An in-flight request cannot be withdrawn: keep it on the bus and
      // drop its data when it finally returns.
      if (state_q == S_REQ) begin
        if (imem_ack_i) begin
          state_q   <= S_IDLE;
          discard_q <= 1'b0;
        end else begin
          discard_q <= 1'b1;
        end
      end
    end else begin
      hbuf_q  <= hbuf_d;
      count_q <= count_d;
      if (fire) begin
        head_pc_q <= head_pc_q + (is_comp ? 32'd2 : 32'd4);
      end
      case (state_q)
        S_IDLE: begin
          if (count_q <= 3'd2) begin
            state_q    <= S_REQ;
            req_addr_q <= fetch_ptr_q;
          end
        end
        S_REQ: begin
          if (imem_ack_i) begin
            state_q <= S_IDLE;
            if (discard_q) begin
              discard_q <= 1'b0;
            end else begin
              fetch_ptr_q <= fetch_ptr_q + 32'd4;
              skip_half_q <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c_fetch_aligner.sv
module tb_c_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_is_comp_o;

  logic        auto_rsp = 1'b0;
  logic        man_ack = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        a_ack = 1'b0;
  logic [31:0] a_rdata = '0;
  int          acks = 0;
  int unsigned wait_cnt = 0;
  int unsigned seed = 32'h1234_5678;
  int unsigned max_lat = 0;
  bit          all_comp = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign imem_ack_i   = auto_rsp ? a_ack : man_ack;
  assign imem_rdata_i = auto_rsp ? a_rdata : man_rdata;

  c_fetch_aligner #(.RESET_PC(32'h8000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ack_i     (imem_ack_i),
    .imem_rdata_i   (imem_rdata_i),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_is_comp_o (inst_is_comp_o)
  );

  // Pseudo-random instruction memory, content is a pure function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    x = (a ^ seed) * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    x = x * 32'h85EB_CA6B;
    x = x ^ (x >> 13);
    if (all_comp) x = (x & 32'hFFFC_FFFC) | 32'h0001_0001;
    return x;
  endfunction

  function automatic logic [15:0] mem_hw(input logic [31:0] a);
    logic [31:0] w;
    w = mem_word({a[31:2], 2'b00});
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Auto-responder with random latency 0..max_lat.
  always @(negedge clk) begin
    a_ack = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (auto_rsp && imem_req_o) begin
      if (wait_cnt == 0) begin
        a_ack   = 1'b1;
        a_rdata = mem_word(imem_addr_o);
        acks    = acks + 1;
        wait_cnt = $urandom_range(0, max_lat);
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic release_reset;
    auto_rsp = 1'b0;
    man_ack = 1'b0;
    redirect_i = 1'b0;
    inst_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    redirect_i = 1'b0;
    inst_ready_i = 1'b0;
    man_ack = 1'b0;
    #3;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    total++; if (imem_addr_o !== 32'h8000_0000) begin bad++; $display("FAIL reset_addr got=%h exp=80000000", imem_addr_o); end
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid_o); end
    total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h exp=0", inst_o); end
    total++; if (inst_pc_o !== 32'h8000_0000) begin bad++; $display("FAIL reset_pc got=%h exp=80000000", inst_pc_o); end
    total++; if (inst_is_comp_o !== 1'b0) begin bad++; $display("FAIL reset_comp got=%b exp=0", inst_is_comp_o); end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0000) begin bad++; $display("FAIL first_req got=%b/%h exp=1/80000000", imem_req_o, imem_addr_o); end
  endtask

  task automatic test_basic;
    release_reset();
    tick();
    man_ack = 1'b1; man_rdata = 32'h0001_4501;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_4501 || inst_pc_o !== 32'h8000_0000 || inst_is_comp_o !== 1'b1)
      begin bad++; $display("FAIL basic_i0 got=%b %h @%h c=%b exp=1 00004501 @80000000 c=1", inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o); end
    inst_ready_i = 1'b1;
    tick();
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0001 || inst_pc_o !== 32'h8000_0002 || inst_is_comp_o !== 1'b1)
      begin bad++; $display("FAIL basic_i1 got=%b %h @%h c=%b exp=1 00000001 @80000002 c=1", inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o); end
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0004) begin bad++; $display("FAIL basic_next_req got=%b/%h exp=1/80000004", imem_req_o, imem_addr_o); end
    inst_ready_i = 1'b0;
  endtask

  task automatic test_straddle;
    release_reset();
    tick();
    man_ack = 1'b1; man_rdata = 32'h0513_4501;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_4501 || inst_pc_o !== 32'h8000_0000)
      begin bad++; $display("FAIL strad_i0 got=%b %h @%h exp=1 00004501 @80000000", inst_valid_o, inst_o, inst_pc_o); end
    inst_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL strad_wait%0d got=%b exp=0", k, inst_valid_o); end
    end
    man_ack = 1'b1; man_rdata = 32'h4505_0000;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_0513 || inst_pc_o !== 32'h8000_0002 || inst_is_comp_o !== 1'b0)
      begin bad++; $display("FAIL strad_i1 got=%b %h @%h c=%b exp=1 00000513 @80000002 c=0", inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o); end
    tick();
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_4505 || inst_pc_o !== 32'h8000_0006 || inst_is_comp_o !== 1'b1)
      begin bad++; $display("FAIL strad_i2 got=%b %h @%h c=%b exp=1 00004505 @80000006 c=1", inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o); end
    inst_ready_i = 1'b0;
  endtask

  task automatic test_redirect_skip;
    release_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0102;
    tick();
    redirect_i = 1'b0;
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL rskip_idle got=%b exp=0", imem_req_o); end
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0100) begin bad++; $display("FAIL rskip_req got=%b/%h exp=1/80000100", imem_req_o, imem_addr_o); end
    man_ack = 1'b1; man_rdata = 32'h4585_FFFF;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_4585 || inst_pc_o !== 32'h8000_0102 || inst_is_comp_o !== 1'b1)
      begin bad++; $display("FAIL rskip_inst got=%b %h @%h c=%b exp=1 00004585 @80000102 c=1", inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o); end
    inst_ready_i = 1'b1;
    tick();
    #1;
    total++; if (inst_valid_o !== 1'b0 || imem_addr_o !== 32'h8000_0104) begin bad++; $display("FAIL rskip_after got=%b/%h exp=0/80000104", inst_valid_o, imem_addr_o); end
    inst_ready_i = 1'b0;
  endtask

  task automatic test_redirect_pending;
    release_reset();
    tick();
    man_ack = 1'b1; man_rdata = 32'h4509_4501;
    tick();
    man_ack = 1'b0;
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0004) begin bad++; $display("FAIL rpend_req got=%b/%h exp=1/80000004", imem_req_o, imem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    #1;
    total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rpend_valid_forced got=%b exp=0", inst_valid_o); end
    tick();
    redirect_i = 1'b0;
    #1;
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0004 || inst_valid_o !== 1'b0)
      begin bad++; $display("FAIL rpend_hold got=%b/%h v=%b exp=1/80000004 v=0", imem_req_o, imem_addr_o, inst_valid_o); end
    tick();
    tick();
    man_ack = 1'b1; man_rdata = 32'h4111_4111;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b0 || imem_req_o !== 1'b0) begin bad++; $display("FAIL rpend_drop got=v%b r%b exp=v0 r0", inst_valid_o, imem_req_o); end
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0200) begin bad++; $display("FAIL rpend_refetch got=%b/%h exp=1/80000200", imem_req_o, imem_addr_o); end
    man_ack = 1'b1; man_rdata = 32'h4605_4601;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_4601 || inst_pc_o !== 32'h8000_0200)
      begin bad++; $display("FAIL rpend_first got=%b %h @%h exp=1 00004601 @80000200", inst_valid_o, inst_o, inst_pc_o); end
  endtask

  task automatic test_backpressure;
    int a0;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    bit seen;
    seed = 32'hA5A5_0001;
    all_comp = 1'b1;
    max_lat = 0;
    release_reset();
    a0 = acks;
    auto_rsp = 1'b1;
    seen = 1'b0;
    hold_inst = '0;
    hold_pc = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      if (inst_valid_o) begin
        if (!seen) begin
          seen = 1'b1;
          hold_inst = inst_o;
          hold_pc = inst_pc_o;
          total++; if (inst_o !== {16'h0, mem_hw(32'h8000_0000)} || inst_pc_o !== 32'h8000_0000)
            begin bad++; $display("FAIL bp_first got=%h @%h exp=%h @80000000", inst_o, inst_pc_o, {16'h0, mem_hw(32'h8000_0000)}); end
        end else begin
          total++; if (inst_o !== hold_inst || inst_pc_o !== hold_pc)
            begin bad++; $display("FAIL bp_stable got=%h @%h exp=%h @%h", inst_o, inst_pc_o, hold_inst, hold_pc); end
        end
      end
    end
    total++; if (acks - a0 != 2) begin bad++; $display("FAIL bp_reqs got=%0d exp=2", acks - a0); end
    inst_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h8000_0000 + 32'(2 * k) ||
                   inst_o !== {16'h0, mem_hw(32'h8000_0000 + 32'(2 * k))})
        begin bad++; $display("FAIL bp_drain%0d got=%b %h @%h exp=1 %h @%h", k, inst_valid_o, inst_o, inst_pc_o,
                              {16'h0, mem_hw(32'h8000_0000 + 32'(2 * k))}, 32'h8000_0000 + 32'(2 * k)); end
      tick();
    end
    inst_ready_i = 1'b0;
    auto_rsp = 1'b0;
    all_comp = 1'b0;
  endtask

  task automatic test_reset_mid;
    release_reset();
    tick();
    man_ack = 1'b1; man_rdata = 32'h4509_4501;
    tick();
    man_ack = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_req_o !== 1'b0 || imem_addr_o !== 32'h8000_0000 || inst_valid_o !== 1'b0 ||
                 inst_o !== 32'h0 || inst_pc_o !== 32'h8000_0000 || inst_is_comp_o !== 1'b0)
      begin bad++; $display("FAIL rstmid_async got=r%b %h v%b %h @%h c%b exp=r0 80000000 v0 0 @80000000 c0",
                            imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_is_comp_o); end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    total++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8000_0000) begin bad++; $display("FAIL rstmid_req got=%b/%h exp=1/80000000", imem_req_o, imem_addr_o); end
    man_ack = 1'b1; man_rdata = 32'h4505_4501;
    tick();
    man_ack = 1'b0;
    #1;
    total++; if (inst_valid_o !== 1'b1 || inst_o !== 32'h0000_4501 || inst_pc_o !== 32'h8000_0000)
      begin bad++; $display("FAIL rstmid_inst got=%b %h @%h exp=1 00004501 @80000000", inst_valid_o, inst_o, inst_pc_o); end
  endtask

  task automatic test_random_stream;
    logic [31:0] exp_pc;
    logic [15:0] h0;
    logic [15:0] h1;
    logic [31:0] exp_inst;
    bit          exp_comp;
    bit          redir;
    bit          stall_prev;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    int          n_hs;
    seed = $urandom;
    all_comp = 1'b0;
    max_lat = 3;
    release_reset();
    auto_rsp = 1'b1;
    exp_pc = 32'h8000_0000;
    stall_prev = 1'b0;
    prev_inst = '0;
    prev_pc = '0;
    n_hs = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      inst_ready_i = ($urandom_range(0, 3) != 0);
      redir = ($urandom_range(0, 39) == 0);
      redirect_i = redir;
      if (redir) redirect_pc_i = 32'h8000_0000 | 32'($urandom_range(0, 65535));
      #1;
      if (imem_req_o) begin
        total++; if (imem_addr_o[1:0] !== 2'b00) begin bad++; $display("FAIL rnd_align got=%h", imem_addr_o); end
      end
      if (stall_prev) begin
        total++; if (inst_o !== prev_inst || inst_pc_o !== prev_pc)
          begin bad++; $display("FAIL rnd_hold got=%h @%h exp=%h @%h", inst_o, inst_pc_o, prev_inst, prev_pc); end
      end
      if (redir) begin
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rnd_redir_valid got=%b exp=0", inst_valid_o); end
        exp_pc = redirect_pc_i & ~32'h1;
      end else if (inst_valid_o && inst_ready_i) begin
        h0 = mem_hw(exp_pc);
        h1 = mem_hw(exp_pc + 32'd2);
        exp_comp = (h0[1:0] != 2'b11);
        exp_inst = exp_comp ? {16'h0, h0} : {h1, h0};
        total++; if (inst_o !== exp_inst || inst_pc_o !== exp_pc || inst_is_comp_o !== exp_comp)
          begin bad++; $display("FAIL rnd_inst got=%h @%h c=%b exp=%h @%h c=%b", inst_o, inst_pc_o, inst_is_comp_o, exp_inst, exp_pc, exp_comp); end
        exp_pc = exp_pc + (exp_comp ? 32'd2 : 32'd4);
        n_hs++;
      end
      stall_prev = inst_valid_o && !inst_ready_i && !redir;
      prev_inst = inst_o;
      prev_pc = inst_pc_o;
    end
    redirect_i = 1'b0;
    inst_ready_i = 1'b0;
    total++; if (n_hs < 200) begin bad++; $display("FAIL rnd_progress got=%0d exp>=200", n_hs); end
    auto_rsp = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_basic();
    test_straddle();
    test_redirect_skip();
    test_redirect_pending();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
